usb_rx_nrzi_unstuff: RTL and testbench

Receive front-end stage that sits directly upstream of the CRC block. It takes synchronized D+/D- samples at each bit-sample strobe and performs four jobs: NRZI-decodes them, removes stuffed bits, detects EOP, and flags line errors. It produces the d_orig / shift_enable pair the CRC block and the RX shift register consume, plus rx_active, eop and rx_error pulses for the RX control FSM.

---
 rtl/usb_rx_pkg.sv | 24 ++
 rtl/usb_nrzi_decode.sv | 29 ++
 rtl/usb_rx_nrzi_unstuff.sv | 147 ++++++++++++++
 tb/tb_usb_rx_nrzi_unstuff.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive front-end.
// Line states are {D+, D-}.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      SE0_ST = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;

   localparam int DEF_STUFF_LEN    = 6;
   localparam int DEF_EOP_SE0_BITS = 2;

   function automatic logic is_jk(input logic [1:0] ls);
      return (ls == LS_J) || (ls == LS_K);
   endfunction

endpackage

// File: rtl/usb_nrzi_decode.sv
// NRZI decoder: remembers the last J/K level and classifies the current
// sample; a bit is 1 when the line did not change since the last J/K.
module usb_nrzi_decode
   import usb_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_d_plus,
   input  logic       i_d_minus,
   input  logic       i_strobe,
   output logic [1:0] o_line_state,
   output logic       o_bit
);

   logic r_prev_line;   // 1 = J, 0 = K

   assign o_line_state = {i_d_plus, i_d_minus};
   assign o_bit        = (i_d_plus == r_prev_line);

   // SE0/SE1 samples leave the reference level untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev_line <= 1'b1;
      end else if (i_strobe && is_jk(o_line_state)) begin
         r_prev_line <= i_d_plus;
      end
   end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front-end: NRZI decode, bit unstuffing, EOP detection and
// line-error flagging, feeding the CRC block and RX shift register.
module usb_rx_nrzi_unstuff
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN    = DEF_STUFF_LEN,
   parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus_sync,
   input  logic d_minus_sync,
   input  logic bit_strobe,
   output logic d_orig,
   output logic shift_enable,
   output logic eop,
   output logic rx_error,
   output logic rx_active
);

   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam int SE0_W  = $clog2(EOP_SE0_BITS) + 1;

   localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LEN);
   localparam logic [SE0_W-1:0]  SE0_MIN    = SE0_W'(EOP_SE0_BITS);
   localparam logic [SE0_W-1:0]  SE0_MAX    = '1;

   state_t            r_state;
   logic [ONES_W-1:0] r_ones_cnt;
   logic [SE0_W-1:0]  r_se0_cnt;
   logic              r_err_j;
   logic              r_armed;

   logic       w_stb;
   logic [1:0] w_ls;
   logic       w_bit;

   // The first edge after reset release never sees a strobe
   assign w_stb = bit_strobe & r_armed;

   usb_nrzi_decode u_decode (
      .clk          (clk),
      .rst          (rst),
      .i_d_plus     (d_plus_sync),
      .i_d_minus    (d_minus_sync),
      .i_strobe     (w_stb),
      .o_line_state (w_ls),
      .o_bit        (w_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_ones_cnt   <= '0;
         r_se0_cnt    <= '0;
         r_err_j      <= 1'b0;
         r_armed      <= 1'b0;
         d_orig       <= 1'b1;
         shift_enable <= 1'b0;
         eop          <= 1'b0;
         rx_error     <= 1'b0;
         rx_active    <= 1'b0;
      end else begin
         r_armed      <= 1'b1;
         shift_enable <= 1'b0;
         eop          <= 1'b0;
         rx_error     <= 1'b0;
         if (w_stb) begin
            unique case (r_state)
               IDLE: begin
                  if (w_ls == LS_K) begin
                     d_orig       <= w_bit;
                     shift_enable <= 1'b1;
                     r_ones_cnt   <= '0;
                     rx_active    <= 1'b1;
                     r_state      <= ACTIVE;
                  end else if (w_ls == LS_SE1) begin
                     rx_error <= 1'b1;
                  end
               end
               ACTIVE: begin
                  case (w_ls)
                     LS_J, LS_K: begin
                        if (r_ones_cnt == ONES_STUFF) begin
                           if (w_bit) begin
                              rx_error   <= 1'b1;
                              r_err_j    <= 1'b0;
                              r_ones_cnt <= '0;
                              r_state    <= ERR;
                           end else begin
                              r_ones_cnt <= '0;
                           end
                        end else begin
                           d_orig       <= w_bit;
                           shift_enable <= 1'b1;
                           r_ones_cnt   <= w_bit ? r_ones_cnt + 1'b1 : '0;
                        end
                     end
                     LS_SE0: begin
                        r_se0_cnt  <= SE0_W'(1);
                        r_ones_cnt <= '0;
                        r_state    <= SE0_ST;
                     end
                     default: begin
                        rx_error <= 1'b1;
                        r_err_j  <= 1'b0;
                        r_state  <= ERR;
                     end
                  endcase
               end
               SE0_ST: begin
                  if (w_ls == LS_SE0) begin
                     if (r_se0_cnt != SE0_MAX) begin
                        r_se0_cnt <= r_se0_cnt + 1'b1;
                     end
                  end else if (w_ls == LS_J && r_se0_cnt >= SE0_MIN) begin
                     eop       <= 1'b1;
                     rx_active <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     rx_error <= 1'b1;
                     r_err_j  <= 1'b0;
                     r_state  <= ERR;
                  end
               end
               ERR: begin
                  // Leave only after two back-to-back J samples
                  if (w_ls == LS_J) begin
                     if (r_err_j) begin
                        rx_active  <= 1'b0;
                        r_ones_cnt <= '0;
                        r_err_j    <= 1'b0;
                        r_state    <= IDLE;
                     end else begin
                        r_err_j <= 1'b1;
                     end
                  end else begin
                     r_err_j <= 1'b0;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Bench: packets are built from payload bits by stuffing and NRZI encoding,
// and each line symbol carries the outputs expected after its strobe.
module tb_usb_rx_nrzi_unstuff;
   import usb_rx_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d_plus_sync = 1'b1;
   logic d_minus_sync = 1'b0;
   logic bit_strobe = 1'b0;
   logic d_orig, shift_enable, eop, rx_error, rx_active;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0] ls;
      bit se;
      bit b;
      bit eop;
      bit err;
      bit act;
   } sym_t;

   sym_t q[$];
   bit   m_line;       // encoder line level, 1 = J
   int   m_ones;       // encoder run of transmitted 1s
   bit   exp_d = 1'b1; // last data bit delivered

   usb_rx_nrzi_unstuff dut (
      .clk          (clk),
      .rst          (rst),
      .d_plus_sync  (d_plus_sync),
      .d_minus_sync (d_minus_sync),
      .bit_strobe   (bit_strobe),
      .d_orig       (d_orig),
      .shift_enable (shift_enable),
      .eop          (eop),
      .rx_error     (rx_error),
      .rx_active    (rx_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] lvl(input bit l);
      return l ? LS_J : LS_K;
   endfunction

   task automatic q_raw(input logic [1:0] ls, input bit se, input bit b,
                        input bit e, input bit er, input bit act);
      sym_t s;
      s.ls = ls; s.se = se; s.b = b; s.eop = e; s.err = er; s.act = act;
      q.push_back(s);
   endtask

   task automatic q_start();
      q.delete();
      m_line = 1'b1;
      m_ones = 0;
   endtask

   // Transmit one data bit; with stuff set, a 0 follows every sixth 1
   task automatic q_bit(input bit b, input bit stuff);
      if (!b) m_line = ~m_line;
      q_raw(lvl(m_line), 1, b, 0, 0, 1);
      m_ones = b ? m_ones + 1 : 0;
      if (stuff && m_ones == 6) begin
         m_line = ~m_line;
         q_raw(lvl(m_line), 0, 0, 0, 0, 1);
         m_ones = 0;
      end
   endtask

   task automatic q_sync();
      for (int i = 0; i < 8; i++) q_bit(i == 7, 1);
   endtask

   task automatic q_eop(input int n_se0);
      for (int i = 0; i < n_se0; i++) q_raw(LS_SE0, 0, 0, 0, 0, 1);
      q_raw(LS_J, 0, 0, 1, 0, 0);
      q_raw(LS_J, 0, 0, 0, 0, 0);
   endtask

   task automatic q_recover();
      q_raw(LS_K, 0, 0, 0, 0, 1);
      q_raw(LS_J, 0, 0, 0, 0, 1);
      q_raw(LS_J, 0, 0, 0, 0, 0);
      q_raw(LS_J, 0, 0, 0, 0, 0);
   endtask

   task automatic strobe_sym(input sym_t s, input string tag);
      int gap;
      @(negedge clk);
      {d_plus_sync, d_minus_sync} = s.ls;
      bit_strobe = 1'b1;
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      if (s.se) exp_d = s.b;
      chk({tag, ".se"},  32'(shift_enable), 32'(s.se));
      chk({tag, ".d"},   32'(d_orig),       32'(exp_d));
      chk({tag, ".eop"}, 32'(eop),          32'(s.eop));
      chk({tag, ".err"}, 32'(rx_error),     32'(s.err));
      chk({tag, ".act"}, 32'(rx_active),    32'(s.act));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         {d_plus_sync, d_minus_sync} = 2'($urandom_range(0, 3));
         @(posedge clk);
         #1;
         chk({tag, ".gap_se"},  32'(shift_enable), 32'd0);
         chk({tag, ".gap_eop"}, 32'(eop),          32'd0);
         chk({tag, ".gap_err"}, 32'(rx_error),     32'd0);
         chk({tag, ".gap_d"},   32'(d_orig),       32'(exp_d));
         chk({tag, ".gap_act"}, 32'(rx_active),    32'(s.act));
      end
   endtask

   task automatic q_run(input string tag);
      for (int i = 0; i < q.size(); i++) strobe_sym(q[i], tag);
      $display("pkt %s: %0d symbols", tag, q.size());
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".d"},   32'(d_orig),       32'd1);
      chk({tag, ".se"},  32'(shift_enable), 32'd0);
      chk({tag, ".eop"}, 32'(eop),          32'd0);
      chk({tag, ".err"}, 32'(rx_error),     32'd0);
      chk({tag, ".act"}, 32'(rx_active),    32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // SYNC followed by a clean EOP
      q_start(); q_sync(); q_eop(2); q_run("sync");

      // Six 1s in a row force a dropped stuffed 0
      q_start(); q_sync();
      for (int i = 0; i < 5; i++) q_bit(1, 1);
      q_bit(0, 1); q_bit(1, 1); q_eop(2); q_run("unstuff");

      // A seventh 1 where the stuffed 0 belongs is an error
      q_start(); q_sync();
      for (int i = 0; i < 5; i++) q_bit(1, 0);
      q_raw(lvl(m_line), 0, 0, 0, 1, 1);
      q_recover(); q_run("stuffviol");

      // Single SE0 then J is a malformed EOP
      q_start(); q_sync(); q_bit(1, 1); q_bit(0, 1);
      q_raw(LS_SE0, 0, 0, 0, 0, 1);
      q_raw(LS_J, 0, 0, 0, 1, 1);
      q_recover(); q_run("shorteop");

      // SE1 while active, then SE1 while idle
      q_start(); q_sync(); q_bit(0, 1);
      q_raw(LS_SE1, 0, 0, 0, 1, 1);
      q_recover();
      q_raw(LS_SE1, 0, 0, 0, 1, 0);
      q_raw(LS_SE0, 0, 0, 0, 0, 0);
      q_raw(LS_J, 0, 0, 0, 0, 0);
      q_run("se1");

      // Async reset after three decoded bits
      q_start();
      for (int i = 0; i < 3; i++) q_bit(0, 1);
      q_run("prerst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      exp_d = 1'b1;
      check_reset_outputs("rst_async");
      @(negedge clk);
      {d_plus_sync, d_minus_sync} = LS_K;
      bit_strobe = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      check_reset_outputs("rst_rel");
      {d_plus_sync, d_minus_sync} = LS_J;
      q_start(); q_sync(); q_bit(1, 1); q_eop(3); q_run("postrst");

      // Random payloads, biased toward long runs of 1s
      for (int p = 0; p < 14; p++) begin
         int nbits;
         nbits = $urandom_range(4, 40);
         q_start(); q_sync();
         for (int i = 0; i < nbits; i++) q_bit($urandom_range(0, 3) != 0, 1);
         q_eop($urandom_range(2, 4));
         q_run($sformatf("rand%0d", p));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
